// File: rtl/control_sel_pkg.sv
// Shared pipeline-control types: sequencer states, stage indices and a
// helper that builds per-stage enable/flush vectors from named bits.
package control_sel_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} pipe_state_t;

  localparam int IFID = 0;
  localparam int IDEX = 1;
  localparam int EXME = 2;

  typedef struct packed {
    logic       pc_en;
    logic [2:0] en;
    logic [2:0] flush;
  } stage_ctl_t;

  function automatic logic [2:0] stage_mask(input logic ifid, input logic idex,
                                            input logic exme);
    logic [2:0] m;
    m       = 3'b000;
    m[IFID] = ifid;
    m[IDEX] = idex;
    m[EXME] = exme;
    return m;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in IDEX whose destination feeds an operand
// of the instruction in IFID. Writes to register 0 are never hazards.
module hazard_detect (
  input  logic       i_idex_memrd,
  input  logic [4:0] i_idex_wreg,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_use_rt,
  output logic       o_ld_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_idex_wreg == i_ifid_rs);
  assign w_rt_hit = i_ifid_use_rt && (i_idex_wreg == i_ifid_rt);
  assign o_ld_use = i_idex_memrd && (i_idex_wreg != 5'd0) && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the IFID/IDEX/EXME pipeline: hazard priority,
// data-memory wait, HALT drain with dcache flush handshake, stall statistics.
module pipeline_ctrl
  import control_sel_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               exme_dren,
  input  logic               exme_dwen,
  input  logic               exme_redirect,
  input  logic               exme_halt,
  input  logic               idex_memrd,
  input  logic [4:0]         idex_wreg,
  input  logic [4:0]         ifid_rs,
  input  logic [4:0]         ifid_rt,
  input  logic               ifid_use_rt,
  input  logic               flush_done,
  input  logic               stat_clr,
  output logic               pc_en,
  output logic [2:0]         stage_en,
  output logic [2:0]         stage_flush,
  output logic               dflush_req,
  output logic               halted,
  output logic [STALL_W-1:0] stall_cnt
);

  pipe_state_t        r_state;
  pipe_state_t        w_next;
  logic               r_halted;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_ld_use;
  logic               w_mem_wait;
  logic               w_count;
  stage_ctl_t         w_run;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard (
    .i_idex_memrd (idex_memrd),
    .i_idex_wreg  (idex_wreg),
    .i_ifid_rs    (ifid_rs),
    .i_ifid_rt    (ifid_rt),
    .i_ifid_use_rt(ifid_use_rt),
    .o_ld_use     (w_ld_use)
  );

  assign w_mem_wait = (exme_dren || exme_dwen) && !dhit;

  // Lower-priority RUN rules, shared by RUN and the dhit cycle of DWAIT
  always_comb begin
    w_run.pc_en = 1'b1;
    w_run.en    = 3'b111;
    w_run.flush = 3'b000;
    if (exme_redirect) begin
      w_run.en    = stage_mask(1'b0, 1'b0, 1'b1);
      w_run.flush = stage_mask(1'b1, 1'b1, 1'b0);
    end else if (w_ld_use) begin
      w_run.pc_en = 1'b0;
      w_run.en    = stage_mask(1'b0, 1'b0, 1'b1);
      w_run.flush = stage_mask(1'b0, 1'b1, 1'b0);
    end else if (!ihit) begin
      w_run.pc_en = 1'b0;
      w_run.en    = stage_mask(1'b0, 1'b1, 1'b1);
      w_run.flush = stage_mask(1'b1, 1'b0, 1'b0);
    end
  end

  always_comb begin
    w_next      = r_state;
    pc_en       = 1'b0;
    stage_en    = 3'b000;
    stage_flush = 3'b000;
    dflush_req  = 1'b0;
    case (r_state)
      RUN: begin
        if (exme_halt) begin
          stage_en    = stage_mask(1'b0, 1'b0, 1'b1);
          stage_flush = stage_mask(1'b1, 1'b1, 1'b0);
          w_next      = DRAIN;
        end else if (w_mem_wait) begin
          w_next = DWAIT;
        end else begin
          {pc_en, stage_en, stage_flush} = w_run;
        end
      end
      DWAIT: begin
        if (dhit) begin
          {pc_en, stage_en, stage_flush} = w_run;
          w_next = RUN;
        end
      end
      DRAIN: begin
        stage_flush = stage_mask(1'b1, 1'b1, 1'b0);
        dflush_req  = 1'b1;
        if (flush_done) w_next = HALTED;
      end
      HALTED: begin
        stage_flush = 3'b111;
      end
      default: w_next = RUN;
    endcase
    if (!nRST) begin
      pc_en       = 1'b0;
      stage_en    = 3'b000;
      stage_flush = 3'b111;
      dflush_req  = 1'b0;
    end
  end

  assign w_count = ((r_state == RUN) || (r_state == DWAIT)) && !pc_en;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == DRAIN) && flush_done) r_halted <= 1'b1;
      if (stat_clr)     r_stall_cnt <= '0;
      else if (w_count) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign halted    = r_halted;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed per-cycle vectors push the
// hand-computed response; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit, exme_dren, exme_dwen, exme_redirect, exme_halt;
  logic          idex_memrd, ifid_use_rt, flush_done, stat_clr;
  logic [4:0]    idex_wreg, ifid_rs, ifid_rt;
  logic          pc_en, dflush_req, halted;
  logic [2:0]    stage_en, stage_flush;
  logic [SW-1:0] stall_cnt;

  typedef struct packed {
    logic          pc;
    logic [2:0]    en;
    logic [2:0]    fl;
    logic          dfr;
    logic          hlt;
    logic [SW-1:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.STALL_W(SW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exme_dren(exme_dren), .exme_dwen(exme_dwen),
    .exme_redirect(exme_redirect), .exme_halt(exme_halt),
    .idex_memrd(idex_memrd), .idex_wreg(idex_wreg),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
    .flush_done(flush_done), .stat_clr(stat_clr),
    .pc_en(pc_en), .stage_en(stage_en), .stage_flush(stage_flush),
    .dflush_req(dflush_req), .halted(halted), .stall_cnt(stall_cnt)
  );

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {pc_en, stage_en, stage_flush, dflush_req, halted, stall_cnt};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got pc=%b en=%b fl=%b dfr=%b hlt=%b cnt=%0d, want pc=%b en=%b fl=%b dfr=%b hlt=%b cnt=%0d",
                 n, a.pc, a.en, a.fl, a.dfr, a.hlt, a.cnt, e.pc, e.en, e.fl, e.dfr, e.hlt, e.cnt);
      end
    end
  end

  task automatic chk(input string nm, input logic pc, input logic [2:0] en,
                     input logic [2:0] fl, input logic dfr, input logic hlt,
                     input logic [SW-1:0] cnt);
    exp_q.push_back({pc, en, fl, dfr, hlt, cnt});
    nm_q.push_back(nm);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; exme_dren = 1'b0; exme_dwen = 1'b0;
    exme_redirect = 1'b0; exme_halt = 1'b0; idex_memrd = 1'b0; idex_wreg = 5'd0;
    ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_use_rt = 1'b0; flush_done = 1'b0; stat_clr = 1'b0;
    @(posedge CLK);
    #1;

    chk("rst0", 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 4'd0);
    chk("rst1", 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 4'd0);
    nRST = 1'b1;
    chk("run_after_rst", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd0);

    idex_memrd = 1'b1; idex_wreg = 5'd5; ifid_rs = 5'd5;
    chk("ld_use_rs", 1'b0, 3'b100, 3'b010, 1'b0, 1'b0, 4'd0);
    idex_memrd = 1'b0;
    chk("ld_use_release", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd1);
    idex_memrd = 1'b1; idex_wreg = 5'd0; ifid_rs = 5'd0;
    chk("ld_use_r0", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd1);
    idex_wreg = 5'd7; ifid_rs = 5'd1; ifid_rt = 5'd7; ifid_use_rt = 1'b1;
    chk("ld_use_rt", 1'b0, 3'b100, 3'b010, 1'b0, 1'b0, 4'd1);
    ifid_use_rt = 1'b0;
    chk("rt_unused", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd2);
    idex_memrd = 1'b0;

    exme_dren = 1'b1; dhit = 1'b0;
    chk("dwait_enter", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 4'd2);
    chk("dwait_hold1", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 4'd3);
    chk("dwait_hold2", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 4'd4);
    dhit = 1'b1;
    chk("dwait_dhit", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd5);
    exme_dren = 1'b0; dhit = 1'b0;
    chk("dwait_resume", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd5);
    exme_dwen = 1'b1; dhit = 1'b1;
    chk("zero_wait_store", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd5);
    exme_dwen = 1'b0; dhit = 1'b0;

    exme_redirect = 1'b1; ihit = 1'b0;
    chk("redirect_miss", 1'b1, 3'b100, 3'b011, 1'b0, 1'b0, 4'd5);
    ihit = 1'b1; idex_memrd = 1'b1; idex_wreg = 5'd5; ifid_rs = 5'd5;
    chk("redirect_over_lduse", 1'b1, 3'b100, 3'b011, 1'b0, 1'b0, 4'd5);
    exme_redirect = 1'b0; idex_memrd = 1'b0; ihit = 1'b0;
    chk("imiss", 1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 4'd5);
    ihit = 1'b1;
    chk("imiss_done", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd6);

    exme_halt = 1'b1;
    chk("halt_run", 1'b0, 3'b100, 3'b011, 1'b0, 1'b0, 4'd6);
    exme_halt = 1'b0;
    chk("drain1", 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 4'd7);
    chk("drain2", 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 4'd7);
    chk("drain3", 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 4'd7);
    flush_done = 1'b1;
    chk("drain_done", 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 4'd7);
    flush_done = 1'b0;
    chk("halted1", 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 4'd7);
    exme_redirect = 1'b1;
    chk("halted2", 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 4'd7);
    exme_redirect = 1'b0; nRST = 1'b0;
    chk("halted_rst", 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 4'd7);
    nRST = 1'b1;
    chk("run_after_halt", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd0);

    exme_halt = 1'b1;
    chk("halt2_run", 1'b0, 3'b100, 3'b011, 1'b0, 1'b0, 4'd0);
    exme_halt = 1'b0;
    chk("drain_b", 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 4'd1);
    nRST = 1'b0;
    chk("drain_rst", 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 4'd1);
    nRST = 1'b1;
    chk("run_after_abort", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd0);

    ihit = 1'b0;
    for (int i = 0; i < 19; i++) begin
      logic [SW-1:0] c;
      c = (i > 15) ? 4'd15 : 4'(i);
      chk("cnt_sat", 1'b0, 3'b110, 3'b001, 1'b0, 1'b0, c);
    end
    stat_clr = 1'b1;
    chk("cnt_clr", 1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 4'd15);
    stat_clr = 1'b0;
    chk("cnt_cleared", 1'b0, 3'b110, 3'b001, 1'b0, 1'b0, 4'd0);
    ihit = 1'b1;
    chk("cnt_restart", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 4'd1);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
